// File: rtl/pe_mac_accum_if.sv
// Operand join channels (filter, ifmap) and psum output channel of the PE MAC stage.
interface pe_mac_accum_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 20
);
    logic                 filt_valid;
    logic                 filt_ready;
    logic [WIDTH-1:0]     filt_data;
    logic                 ifmap_valid;
    logic                 ifmap_ready;
    logic [WIDTH-1:0]     ifmap_data;
    logic                 psum_valid;
    logic                 psum_ready;
    logic [ACC_WIDTH-1:0] psum_data;

    modport master (
        output filt_valid, filt_data, ifmap_valid, ifmap_data, psum_ready,
        input  filt_ready, ifmap_ready, psum_valid, psum_data
    );

    modport slave (
        input  filt_valid, filt_data, ifmap_valid, ifmap_data, psum_ready,
        output filt_ready, ifmap_ready, psum_valid, psum_data
    );
endinterface

// File: rtl/pe_mac_accum.sv
// Joins filter/ifmap operands, accumulates NUM_MAC unsigned products, emits one psum.
// Optional macro PE_MAC_SAT_EN: saturating accumulation instead of modulo wrap.
module pe_mac_accum #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 20,
    parameter int unsigned NUM_MAC   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    pe_mac_accum_if.slave bus,
    output logic          busy
);
    localparam int unsigned CNT_W  = $clog2(NUM_MAC + 1);
    localparam int unsigned PROD_W = 2 * WIDTH;

    typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0]     r_count;
    logic                 r_psum_valid;
    logic [ACC_WIDTH-1:0] r_psum_data;
    logic [PROD_W-1:0]    w_prod;
    logic                 w_join;
    logic                 w_last;
    logic                 w_psum_hs;
    logic                 w_filt_ready;
    logic                 w_ifmap_ready;

    assign w_join    = (r_state == ST_ACC) && bus.filt_valid && bus.ifmap_valid;
    assign w_last    = (r_count == CNT_W'(NUM_MAC - 1));
    assign w_psum_hs = r_psum_valid && bus.psum_ready;
    assign w_prod    = PROD_W'(bus.filt_data) * PROD_W'(bus.ifmap_data);

`ifdef PE_MAC_SAT_EN
    // Carry out of the widened sum clamps the accumulator to all-ones.
    logic [ACC_WIDTH:0] w_sum;
    assign w_sum     = {1'b0, r_acc} + (ACC_WIDTH + 1)'(w_prod);
    assign w_acc_nxt = w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
    assign w_acc_nxt = r_acc + ACC_WIDTH'(w_prod);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC: if (w_join && w_last) w_state_nxt = ST_OUT;
            ST_OUT: if (w_psum_hs)        w_state_nxt = ST_ACC;
            default:                      w_state_nxt = ST_ACC;
        endcase
    end

    // Each ready follows the other channel's valid so both operands move together.
    always_comb begin
        w_filt_ready  = 1'b0;
        w_ifmap_ready = 1'b0;
        if (r_state == ST_ACC) begin
            w_filt_ready  = bus.ifmap_valid;
            w_ifmap_ready = bus.filt_valid;
        end
    end

    // Accumulator, product counter and psum output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_count      <= '0;
            r_psum_valid <= 1'b0;
            r_psum_data  <= '0;
        end else if (w_join) begin
            r_acc   <= w_acc_nxt;
            r_count <= r_count + CNT_W'(1);
            if (w_last) begin
                r_psum_valid <= 1'b1;
                r_psum_data  <= w_acc_nxt;
            end
        end else if (w_psum_hs) begin
            r_acc        <= '0;
            r_count      <= '0;
            r_psum_valid <= 1'b0;
        end
    end

    assign bus.filt_ready  = w_filt_ready;
    assign bus.ifmap_ready = w_ifmap_ready;
    assign bus.psum_valid  = r_psum_valid;
    assign bus.psum_data   = r_psum_data;
    assign busy            = (r_count != '0) || r_psum_valid;
endmodule
